// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings for the two-requester ALU arbiter: ALU functions, FSM states
// and condition-code layout.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Bit positions inside cc = {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_share_arbiter_alu64.sv
// Combinational WIDTH-bit ALU (add/sub/and/xor) with a signed-overflow flag.
// Add and subtract share a single adder: subtract feeds ~b with a carry-in of 1.
module alu64
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  alu_fn_e          fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             of
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_of;

  // With b_eff already inverted for subtract, one overflow rule covers both ops
  always_comb begin
    is_sub = (fn == ALU_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    sum_of = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fn)
      ALU_ADD, ALU_SUB: begin
        result = sum;
        of     = sum_of;
      end
      ALU_AND: result = a & b;
      ALU_XOR: result = a ^ b;
      default: begin
        result = '0;
        of     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; latches operands,
// executes for one cycle, holds the result under a valid/ready handshake and owns cc.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_fn,
  input  logic             req0_setcc,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_fn,
  input  logic             req1_setcc,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,

  output logic [2:0]       cc,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_fn_e          fn_q, fn_d;
  logic             setcc_q, setcc_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       cc_q, cc_d;

  logic             any_valid;
  logic             grant_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_of;

  // On a tie the requester that did not win last time is granted
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant_id;

  alu64 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .fn     (fn_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .of     (alu_of)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    fn_d         = fn_q;
    setcc_d      = setcc_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    cc_d         = cc_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          id_d    = grant_id;
          last_d  = grant_id;
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          fn_d    = alu_fn_e'(grant_id ? req1_fn : req0_fn);
          setcc_d = grant_id ? req1_setcc : req0_setcc;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        if (setcc_q) begin
          cc_d[CC_ZF] = (alu_result == '0);
          cc_d[CC_SF] = alu_result[WIDTH-1];
          cc_d[CC_OF] = alu_of;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset aborts any in-flight transaction without issuing a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      fn_q         <= ALU_ADD;
      setcc_q      <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      cc_q         <= CC_RESET;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      fn_q         <= fn_d;
      setcc_q      <= setcc_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      cc_q         <= cc_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign cc         = cc_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_setcc;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [1:0]       req0_fn;
  logic             req1_valid, req1_ready, req1_setcc;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [1:0]       req1_fn;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       cc;
  logic             busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fn    (req0_fn),
    .req0_setcc (req0_setcc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fn    (req1_fn),
    .req1_setcc (req1_setcc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .cc         (cc),
    .busy       (busy)
  );

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  fn;
    logic        setcc;
    logic [63:0] expResult;
    logic [2:0]  expCc;
  } vec_t;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model: phase 0 idle, 1 executing, 2 holding a response
  int          mdlPhase;
  logic        mdlLast;
  logic [2:0]  mdlCc;
  logic        mdlId;
  logic [63:0] mdlRes;
  logic        mdlSet;
  logic [2:0]  mdlCcNew;
  logic        expR0, expR1;
  bit          accepted [2];
  int          grantLog[$];
  int          rspIdLog[$];
  logic [63:0] rspResLog[$];
  int          dutHandshakes = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Signed overflow from a sign-extended 65-bit result: top two bits disagree
  function automatic void refAlu(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fn,
                                 output logic [63:0] res, output logic [2:0] ccOut);
    logic [64:0] wide;
    logic        ovf;
    case (fn)
      2'b00:   wide = {a[63], a} + {b[63], b};
      2'b01:   wide = {a[63], a} - {b[63], b};
      2'b10:   wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    res   = wide[63:0];
    ovf   = (fn[1] == 1'b0) && (wide[64] != wide[63]);
    ccOut = {res == 64'd0, res[63], ovf};
  endfunction

  task automatic compareAll();
    expR0 = (mdlPhase == 0) && req0_valid && (!req1_valid || mdlLast);
    expR1 = (mdlPhase == 0) && req1_valid && (!req0_valid || !mdlLast);
    checkOutput("req0_ready", 64'(req0_ready), 64'(expR0));
    checkOutput("req1_ready", 64'(req1_ready), 64'(expR1));
    checkOutput("busy", 64'(busy), 64'(mdlPhase != 0));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(mdlPhase == 2));
    checkOutput("cc", 64'(cc), 64'(mdlCc));
    if (mdlPhase == 2) begin
      checkOutput("rsp_id", 64'(rsp_id), 64'(mdlId));
      checkOutput("rsp_result", rsp_result, mdlRes);
    end
    if (rsp_valid && rsp_ready) dutHandshakes++;
  endtask

  task automatic advanceModel();
    if (rst) begin
      mdlPhase = 0;
      mdlLast  = 1'b1;
      mdlCc    = 3'b100;
    end else begin
      case (mdlPhase)
        0: if (expR0 || expR1) begin
          mdlId = expR1;
          if (expR1) begin
            refAlu(req1_a, req1_b, req1_fn, mdlRes, mdlCcNew);
            mdlSet = req1_setcc;
          end else begin
            refAlu(req0_a, req0_b, req0_fn, mdlRes, mdlCcNew);
            mdlSet = req0_setcc;
          end
          mdlLast         = mdlId;
          accepted[mdlId] = 1'b1;
          grantLog.push_back(int'(mdlId));
          mdlPhase = 1;
        end
        1: begin
          if (mdlSet) mdlCc = mdlCcNew;
          mdlPhase = 2;
        end
        default: if (rsp_ready) begin
          rspIdLog.push_back(int'(mdlId));
          rspResLog.push_back(mdlRes);
          mdlPhase = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    #1;
    compareAll();
    @(posedge clk);
    advanceModel();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit who, input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] fn, input logic setcc);
    if (who == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fn = fn; req0_setcc = setcc;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fn = fn; req1_setcc = setcc;
    end
  endtask

  task automatic dropReq(input bit who);
    if (who == 1'b0) req0_valid = 1'b0;
    else             req1_valid = 1'b0;
  endtask

  task automatic waitAccept(input bit who, input string name);
    int waited = 0;
    while (!accepted[who] && waited < 12) begin
      tick();
      waited++;
    end
    checkOutput(name, 64'(accepted[who]), 64'd1);
    accepted[who] = 1'b0;
  endtask

  task automatic waitIdle();
    int waited = 0;
    while (mdlPhase != 0 && waited < 30) begin
      tick();
      waited++;
    end
    checkOutput("drain_timeout", 64'(mdlPhase), 64'd0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    rsp_ready = 1'b1;
    accepted  = '{1'b0, 1'b0};
    applyStimulus(v.id, v.a, v.b, v.fn, v.setcc);
    waitAccept(v.id, {tag, "_accept"});
    dropReq(v.id);
    checkOutput({tag, "_exec_no_rsp"}, 64'(rsp_valid), 64'd0);
    tick();
    checkOutput({tag, "_latency"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_result"}, rsp_result, v.expResult);
    checkOutput({tag, "_id"}, 64'(rsp_id), 64'(v.id));
    checkOutput({tag, "_cc"}, 64'(cc), 64'(v.expCc));
    tick();
    checkOutput({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs [9];
    logic [63:0] held;
    int          hsBefore;
    bit          pending [2];
    logic [63:0] ra, rb;

    vecs[0] = '{1'b0, 64'h0, 64'h1, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010};
    vecs[1] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 2'b01, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
    vecs[2] = '{1'b0, 64'h5, 64'h5, 2'b11, 1'b0, 64'h0, 3'b001};
    vecs[3] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b1, 64'h8000_0000_0000_0000, 3'b011};
    vecs[4] = '{1'b0, 64'hF0, 64'h0F, 2'b10, 1'b1, 64'h0, 3'b100};
    vecs[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010};
    vecs[6] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b1, 64'h8000_0000_0000_0000, 3'b011};
    vecs[7] = '{1'b0, 64'hFF00, 64'h0F0F, 2'b11, 1'b1, 64'hF00F, 3'b000};
    vecs[8] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b1, 64'h0, 3'b100};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fn = 2'b00; req0_setcc = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fn = 2'b00; req1_setcc = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mdlPhase = 0; mdlLast = 1'b1; mdlCc = 3'b100; mdlId = 1'b0; mdlRes = '0; mdlSet = 1'b0;
    accepted = '{1'b0, 1'b0};

    // Reset state
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_cc", 64'(cc), 64'd4);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("reset_rsp_result", rsp_result, 64'd0);
    checkOutput("reset_req0_ready", 64'(req0_ready), 64'd0);
    checkOutput("reset_req1_ready", 64'(req1_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] sustained contention");
    grantLog.delete(); rspIdLog.delete(); rspResLog.delete();
    accepted  = '{1'b0, 1'b0};
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 64'd1, 64'd1, 2'b00, 1'b0);
    applyStimulus(1'b1, 64'hF0, 64'h0F, 2'b10, 1'b0);
    for (int c = 0; c < 40 && grantLog.size() < 4; c++) tick();
    dropReq(1'b0);
    dropReq(1'b1);
    waitIdle();
    checkOutput("contention_grant_count", 64'(grantLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) begin
      checkOutput($sformatf("contention_grant%0d", i), 64'(grantLog[i]), 64'(i % 2));
    end
    checkOutput("contention_rsp_count", 64'(rspIdLog.size()), 64'd4);
    for (int i = 0; i < 4 && i < rspIdLog.size(); i++) begin
      checkOutput($sformatf("contention_rsp_id%0d", i), 64'(rspIdLog[i]), 64'(i % 2));
      checkOutput($sformatf("contention_rsp_res%0d", i), rspResLog[i], (i % 2 == 0) ? 64'd2 : 64'd0);
    end

    $display("[TB] response backpressure");
    accepted  = '{1'b0, 1'b0};
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 64'd10, 64'd20, 2'b00, 1'b1);
    waitAccept(1'b0, "bp_accept");
    dropReq(1'b0);
    applyStimulus(1'b1, 64'd9, 64'd4, 2'b01, 1'b0);
    tick();
    held = rsp_result;
    for (int s = 0; s < 5; s++) begin
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_rsp_result", rsp_result, 64'd30);
      checkOutput("bp_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput("bp_req0_ready", 64'(req0_ready), 64'd0);
      checkOutput("bp_req1_ready", 64'(req1_ready), 64'd0);
      tick();
    end
    checkOutput("bp_result_stable", rsp_result, held);
    hsBefore  = dutHandshakes;
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_one_handshake", 64'(dutHandshakes - hsBefore), 64'd1);
    checkOutput("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
    checkOutput("bp_idle_after", 64'(busy), 64'd0);
    waitAccept(1'b1, "bp_pending_req1");
    dropReq(1'b1);
    waitIdle();
    checkOutput("bp_total_handshakes", 64'(dutHandshakes - hsBefore), 64'd2);

    $display("[TB] reset during execute");
    accepted = '{1'b0, 1'b0};
    applyStimulus(1'b0, 64'd3, 64'd4, 2'b00, 1'b1);
    waitAccept(1'b0, "rst_accept");
    dropReq(1'b0);
    checkOutput("rst_in_exec", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      checkOutput("rst_no_rsp", 64'(rsp_valid), 64'd0);
      checkOutput("rst_cc", 64'(cc), 64'd4);
      tick();
    end
    runVector('{1'b0, 64'd3, 64'd4, 2'b00, 1'b1, 64'd7, 3'b000}, "post_rst");

    $display("[TB] randomized traffic");
    pending  = '{1'b0, 1'b0};
    accepted = '{1'b0, 1'b0};
    for (int c = 0; c < 600; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (accepted[x]) begin
          pending[x]  = 1'b0;
          accepted[x] = 1'b0;
        end
        if (!pending[x] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 3))
            0:       begin ra = 64'($urandom_range(0, 15)); rb = 64'($urandom_range(0, 15)); end
            1:       begin ra = 64'h8000_0000_0000_0000; rb = {32'($urandom), 32'($urandom)}; end
            2:       begin ra = 64'h7FFF_FFFF_FFFF_FFFF; rb = 64'($urandom_range(0, 3)); end
            default: begin ra = {32'($urandom), 32'($urandom)}; rb = {32'($urandom), 32'($urandom)}; end
          endcase
          applyStimulus(x[0], ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          pending[x] = 1'b1;
        end else if (!pending[x]) begin
          dropReq(x[0]);
          if (x == 0) begin req0_a = {32'($urandom), 32'($urandom)}; req0_fn = 2'($urandom_range(0, 3)); end
          else        begin req1_b = {32'($urandom), 32'($urandom)}; req1_fn = 2'($urandom_range(0, 3)); end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst       = 1'b0;
    rsp_ready = 1'b1;
    dropReq(1'b0);
    dropReq(1'b1);
    tick();
    waitIdle();

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
